vga_timing_gen: RTL

Upstream pixel-timing stage for the Lab 5 VGA controller. Runs on the 100 MHz board clock and derives a 25 MHz pixel-enable tick. Produces 640x480@60 horizontal/vertical counters, active-low Hsync/Vsync, a video_on window and line/frame strobes. The colour/switch logic consumes these outputs to drive vgaRed/vgaGreen/vgaBlue.

---
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel timing: divides the board clock into a pixel tick and
// produces h/v counters, active-low syncs, video window and line/frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 659,
  parameter int H_SYNC_END   = 755,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 493,
  parameter int V_SYNC_END   = 494,
  parameter int V_TOTAL      = 525
) (
  input  logic       clk_100Mhz,
  input  logic       reset_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       Hsync,
  output logic       Vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int                DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]        H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]        HS_LO    = 10'(H_SYNC_START);
  localparam logic [9:0]        HS_HI    = 10'(H_SYNC_END);
  localparam logic [9:0]        VS_LO    = 10'(V_SYNC_START);
  localparam logic [9:0]        VS_HI    = 10'(V_SYNC_END);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             advance_s;
  logic [9:0]       h_nxt_s;
  logic [9:0]       v_nxt_s;
  logic             hsync_nxt_s;
  logic             vsync_nxt_s;
  logic             video_nxt_s;
  logic             line_nxt_s;
  logic             frame_nxt_s;

  // Sync is low across an inclusive window of counter values.
  function automatic logic sync_level(input logic [9:0] pos,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
    return !((pos >= lo) && (pos <= hi));
  endfunction

  // Divider phase and raster position for the next edge.
  always_comb begin
    div_nxt_s = div_r;
    advance_s = 1'b0;
    h_nxt_s   = hcount;
    v_nxt_s   = vcount;
    if (en) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s = {DIV_W{1'b0}};
        advance_s = 1'b1;
      end else begin
        div_nxt_s = div_r + DIV_ONE;
      end
    end else begin
      div_nxt_s = div_r;
    end
    if (advance_s) begin
      if (hcount == H_LAST) begin
        h_nxt_s = 10'd0;
        if (vcount == V_LAST) begin
          v_nxt_s = 10'd0;
        end else begin
          v_nxt_s = vcount + 10'd1;
        end
      end else begin
        h_nxt_s = hcount + 10'd1;
        v_nxt_s = vcount;
      end
    end else begin
      h_nxt_s = hcount;
      v_nxt_s = vcount;
    end
  end

  // Decode from the new position so syncs line up with the counters.
  always_comb begin
    hsync_nxt_s = Hsync;
    vsync_nxt_s = Vsync;
    video_nxt_s = video_on;
    if (advance_s) begin
      hsync_nxt_s = sync_level(h_nxt_s, HS_LO, HS_HI);
      vsync_nxt_s = sync_level(v_nxt_s, VS_LO, VS_HI);
      video_nxt_s = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
    end else begin
      hsync_nxt_s = Hsync;
      vsync_nxt_s = Vsync;
      video_nxt_s = video_on;
    end
    line_nxt_s  = advance_s && (h_nxt_s == 10'd0);
    frame_nxt_s = line_nxt_s && (v_nxt_s == 10'd0);
  end

  // State and output registers; reset parks at the last position of a frame.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      div_r       <= {DIV_W{1'b0}};
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      video_on    <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_r       <= div_nxt_s;
      hcount      <= h_nxt_s;
      vcount      <= v_nxt_s;
      Hsync       <= hsync_nxt_s;
      Vsync       <= vsync_nxt_s;
      video_on    <= video_nxt_s;
      pix_tick    <= advance_s;
      line_start  <= line_nxt_s;
      frame_start <= frame_nxt_s;
    end
  end

endmodule
